// File: rtl/cdm_pkg.sv
// Shared definitions for the carry-disregard pipelined array multiplier:
// parameter legality check, column XOR helper and the per-stage control record.
package cdm_pkg;

  localparam int MAX_W = 32;

  typedef struct packed {
    logic valid;
    logic approx;
  } stage_ctl_t;

  function automatic bit params_ok(input int width, input int stages, input int approx_k);
    return (width > 0) && (width <= MAX_W) && (stages > 0) && ((width % stages) == 0) &&
           (approx_k >= 0) && (approx_k <= 2 * width);
  endfunction

  // XOR of every partial-product bit a[i]&b[j] that lands in column c = i+j.
  function automatic logic col_xor(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                   input int c);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((c - i >= 0) && (c - i < MAX_W)) begin
        x = x ^ (a[i] & b[c-i]);
      end
    end
    return x;
  endfunction

endpackage

// File: rtl/cdm_row_stage.sv
// One multiplier pipeline stage: folds ROWS multiplier rows into the exact,
// high-column and low-column-XOR accumulators, then registers them under enable.
module cdm_row_stage
  import cdm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int APPROX_K  = 4,
  parameter int ROWS      = 4,
  parameter int FIRST_ROW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  stage_ctl_t         ctl_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [2*WIDTH-1:0] exact_in,
  input  logic [2*WIDTH-1:0] hi_in,
  input  logic [2*WIDTH-1:0] lo_in,
  output stage_ctl_t         ctl_out,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [2*WIDTH-1:0] exact_out,
  output logic [2*WIDTH-1:0] hi_out,
  output logic [2*WIDTH-1:0] lo_out
);

  localparam int PW = 2 * WIDTH;
  // Columns below APPROX_K are carry-free; with APPROX_K=0 the mask is empty.
  localparam logic [PW-1:0] LO_MASK = {PW{1'b1}} >> (PW - APPROX_K);

  logic [PW-1:0]    exact_nx;
  logic [PW-1:0]    hi_nx;
  logic [PW-1:0]    lo_nx;
  logic [PW-1:0]    row;
  logic [MAX_W-1:0] a_ext;
  logic [MAX_W-1:0] b_ext;

  always_comb begin
    exact_nx = exact_in;
    hi_nx    = hi_in;
    lo_nx    = lo_in;
    row      = '0;
    a_ext    = '0;
    b_ext    = '0;
    a_ext[WIDTH-1:0] = a_in;
    for (int r = 0; r < ROWS; r++) begin
      b_ext[FIRST_ROW+r] = b_in[FIRST_ROW+r];
      row = {{WIDTH{1'b0}}, a_in} << (FIRST_ROW + r);
      if (b_in[FIRST_ROW+r]) begin
        exact_nx = exact_nx + row;
        hi_nx    = hi_nx + (row & ~LO_MASK);
      end
    end
    // High sums never see the low columns, so no carry crosses into column APPROX_K.
    for (int c = 0; c < PW; c++) begin
      if (c < APPROX_K) begin
        lo_nx[c] = lo_in[c] ^ col_xor(a_ext, b_ext, c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_out   <= '0;
      a_out     <= '0;
      b_out     <= '0;
      exact_out <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else if (en) begin
      ctl_out <= ctl_in;
      if (ctl_in.valid) begin
        a_out     <= a_in;
        b_out     <= b_in;
        exact_out <= exact_nx;
        hi_out    <= hi_nx;
        lo_out    <= lo_nx;
      end
    end
  end

endmodule

// File: rtl/cdm_array_mul_pipe.sv
// Pipelined unsigned array multiplier with per-beat carry-disregard approximation
// of the low product columns, valid/ready handshakes and an approximate-beat counter.
module cdm_array_mul_pipe
  import cdm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int APPROX_K = 4,
  parameter int STAGES   = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int R = WIDTH / STAGES;

  if (!params_ok(WIDTH, STAGES, APPROX_K)) begin : g_bad_params
    $error("cdm_array_mul_pipe: illegal WIDTH/STAGES/APPROX_K combination");
  end

  stage_ctl_t         ctl   [STAGES+1];
  logic [WIDTH-1:0]   a_s   [STAGES+1];
  logic [WIDTH-1:0]   b_s   [STAGES+1];
  logic [2*WIDTH-1:0] exact [STAGES+1];
  logic [2*WIDTH-1:0] hi    [STAGES+1];
  logic [2*WIDTH-1:0] lo    [STAGES+1];

  logic             stall;
  logic [CNT_W-1:0] cnt;
  logic             unused_tail;

  assign ctl[0]   = {in_valid, in_approx};
  assign a_s[0]   = in_a;
  assign b_s[0]   = in_b;
  assign exact[0] = '0;
  assign hi[0]    = '0;
  assign lo[0]    = '0;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    cdm_row_stage #(
      .WIDTH    (WIDTH),
      .APPROX_K (APPROX_K),
      .ROWS     (R),
      .FIRST_ROW(s * R)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (~stall),
      .ctl_in   (ctl[s]),
      .a_in     (a_s[s]),
      .b_in     (b_s[s]),
      .exact_in (exact[s]),
      .hi_in    (hi[s]),
      .lo_in    (lo[s]),
      .ctl_out  (ctl[s+1]),
      .a_out    (a_s[s+1]),
      .b_out    (b_s[s+1]),
      .exact_out(exact[s+1]),
      .hi_out   (hi[s+1]),
      .lo_out   (lo[s+1])
    );
  end

  // Operands leaving the final stage are no longer needed.
  assign unused_tail = ^{a_s[STAGES], b_s[STAGES]};

  // A full output that is not taken freezes the whole pipe.
  assign stall      = out_valid & ~out_ready;
  assign in_ready   = ~stall;
  assign out_valid  = ctl[STAGES].valid;
  assign out_approx = ctl[STAGES].approx;
  assign out_p      = ctl[STAGES].approx ? (hi[STAGES] | lo[STAGES]) : exact[STAGES];
  assign approx_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_valid && out_ready && out_approx && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_cdm_array_mul_pipe.sv
// Self-checking bench: directed and random beats against a column-count reference
// model with a latency-tracking scoreboard; a CNT_W=2 twin checks counter saturation.
module tb_cdm_array_mul_pipe;

  localparam int W      = 8;
  localparam int K      = 4;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic        in_approx;
  logic        out_valid;
  logic        out_ready;
  logic [2*W-1:0] out_p;
  logic        out_approx;
  logic [15:0] approx_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [2*W-1:0] out_p2;
  logic        out_approx2;
  logic [1:0]  approx_cnt2;

  always #5 clk = ~clk;

  cdm_array_mul_pipe #(.WIDTH(W), .APPROX_K(K), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_approx(out_approx), .approx_cnt(approx_cnt)
  );

  cdm_array_mul_pipe #(.WIDTH(W), .APPROX_K(K), .STAGES(STAGES), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a),
    .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid2), .out_ready(out_ready),
    .out_p(out_p2), .out_approx(out_approx2), .approx_cnt(approx_cnt2)
  );

  typedef struct {
    int p;
    bit ap;
    int age;
  } item_t;

  item_t q[$];
  int n_asrt = 0;
  int n_fail = 0;
  int cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count partial-product bits per column, XOR below K, weighted sum above.
  function automatic int golden(input int a, input int b, input bit ap);
    int hi, lo, cnt;
    if (!ap) return a * b;
    hi = 0;
    lo = 0;
    for (int c = 0; c < 2 * W; c++) begin
      cnt = 0;
      for (int i = 0; i < W; i++) begin
        if (c - i >= 0 && c - i < W) cnt += ((a >> i) & 1) & ((b >> (c - i)) & 1);
      end
      if (c < K) lo |= (cnt & 1) << c;
      else hi += cnt << c;
    end
    return hi | lo;
  endfunction

  task automatic cycle(input logic v, input int a, input int b, input logic ap,
                       input logic ordy, input bit ov = 1'b0, input int ovp = 0);
    item_t it;
    bit exp_v;
    bit stall_now;
    @(negedge clk);
    in_valid  = v;
    in_a      = a[W-1:0];
    in_b      = b[W-1:0];
    in_approx = ap;
    out_ready = ordy;
    #1;
    exp_v     = (q.size() > 0) && (q[0].age >= STAGES);
    stall_now = exp_v && !ordy;
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("in_ready", 32'(in_ready), 32'(!stall_now));
    chk("approx_cnt", 32'(approx_cnt), 32'((cnt_model > 65535) ? 65535 : cnt_model));
    chk("approx_cnt_sat", 32'(approx_cnt2), 32'((cnt_model > 3) ? 3 : cnt_model));
    if (stall_now) begin
      chk("stall_hold_p", 32'(out_p), 32'(q[0].p));
    end
    if (exp_v && ordy) begin
      it = q.pop_front();
      chk("out_p", 32'(out_p), 32'(it.p));
      chk("out_approx", 32'(out_approx), 32'(it.ap));
      chk("out_p_twin", 32'(out_p2), 32'(it.p));
      if (it.ap) cnt_model++;
    end
    if (v && !stall_now) begin
      it.p   = ov ? ovp : golden(a & 255, b & 255, ap);
      it.ap  = ap;
      it.age = 0;
      q.push_back(it);
    end
    if (!stall_now) begin
      foreach (q[i]) q[i].age++;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle(1'b0, 0, 0, 1'b0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h0F;
    in_b      = 8'h0F;
    in_approx = 1'b1;
    out_ready = 1'b1;

    // Reset held with a valid beat offered: nothing may enter or emerge.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_approx_cnt", 32'(approx_cnt), 32'd0);
      chk("rst_out_p", 32'(out_p), 32'd0);
      chk("rst_out_approx", 32'(out_approx), 32'd0);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < STAGES + 1; k++) cycle(1'b0, 8'h0F, 8'h0F, 1'b1, 1'b1);

    // Directed products with values fixed from the column rules.
    cycle(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1, 1'b1, 32'h00E1);
    cycle(1'b1, 8'h0F, 8'h0F, 1'b1, 1'b1, 1'b1, 32'h00B5);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 32'hFE01);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 32'hFDD5);
    cycle(1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 32'h0000);
    drain();

    // Back-to-back random beats at full throughput.
    for (int k = 0; k < 100; k++)
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Idle cycles with garbage operands must not create beats.
    for (int k = 0; k < 4; k++)
      cycle(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1'b1);

    // Fill the pipe, then hold out_ready low for 5 cycles.
    for (int k = 0; k < 3; k++)
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b1);
    for (int k = 0; k < 5; k++)
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Random valid and ready patterns.
    for (int k = 0; k < 60; k++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset while beats are in flight empties the pipe and clears the counter.
    for (int k = 0; k < 3; k++)
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1'b1);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_approx_cnt", 32'(approx_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    cnt_model = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < STAGES + 1; k++) cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1);
    cycle(1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1);
    drain();
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
